// File: rtl/fp_shift_pkg.sv
// Shared mode encodings and per-stage control payload for the pipelined barrel shifter.
package fp_shift_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  // Width-independent part of the stage payload; data/amt/tag ride alongside as parameterized vectors.
  typedef struct packed {
    logic       valid;
    logic [1:0] mode;
    logic       ovf;
    logic       sticky;
  } stage_ctrl_t;

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One registered 2:1 mux level shifting by 2^K when amt[K] is set.
// Sticky accumulation is built only when SHIFTER_STICKY_EN is defined.
module shift_stage
  import fp_shift_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int TAG_W = 8,
  parameter int K     = 0,
  parameter int SHW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  stage_ctrl_t      in_ctrl,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [TAG_W-1:0] in_tag,
  output stage_ctrl_t      out_ctrl,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amt,
  output logic [TAG_W-1:0] out_tag
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] nxt_data;
  logic             nxt_sticky;
  stage_ctrl_t      nxt_ctrl;

  // Reserved mode 11 falls into the logical-right default.
  always_comb begin
    shifted = in_data >> S;
    case (in_ctrl.mode)
      MODE_LSL: shifted = in_data << S;
      MODE_ASR: shifted = $signed(in_data) >>> S;
      default:  ;
    endcase
    nxt_data = in_amt[K] ? shifted : in_data;
  end

`ifdef SHIFTER_STICKY_EN
  logic [S-1:0] spill;
  assign spill      = (in_ctrl.mode == MODE_LSL) ? in_data[WIDTH-1 -: S] : in_data[S-1:0];
  assign nxt_sticky = in_ctrl.sticky | (in_amt[K] & (|spill));
`else
  assign nxt_sticky = in_ctrl.sticky;
`endif

  always_comb begin
    nxt_ctrl        = in_ctrl;
    nxt_ctrl.sticky = nxt_sticky;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ctrl <= '0;
      out_data <= '0;
      out_amt  <= '0;
      out_tag  <= '0;
    end else if (en) begin
      out_ctrl <= nxt_ctrl;
      out_data <= nxt_data;
      out_amt  <= in_amt;
      out_tag  <= in_tag;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Log-depth pipelined barrel shifter (LSL/LSR/ASR) with global-stall backpressure.
// Optional sticky output enabled by defining SHIFTER_STICKY_EN.
module pipelined_barrel_shifter
  import fp_shift_pkg::*;
#(
  parameter  int WIDTH  = 24,
  parameter  int TAG_W  = 8,
  localparam int LEVELS = $clog2(WIDTH),
  localparam int SHW    = LEVELS + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sticky
);

  stage_ctrl_t [LEVELS:0]            st_ctrl;
  logic        [LEVELS:0][WIDTH-1:0] st_data;
  logic        [LEVELS:0][SHW-1:0]   st_amt;
  logic        [LEVELS:0][TAG_W-1:0] st_tag;

  logic en;
  logic ovf;
  logic sticky0;

  assign en       = !st_ctrl[LEVELS].valid | out_ready;
  assign in_ready = en;
  assign ovf      = in_amt >= SHW'(WIDTH);

`ifdef SHIFTER_STICKY_EN
  // Overflow discards every operand bit, so seed sticky with the whole operand.
  assign sticky0 = ovf & (|in_data);
`else
  assign sticky0 = 1'b0;
`endif

  assign st_ctrl[0] = '{valid: in_valid, mode: in_mode, ovf: ovf, sticky: sticky0};
  assign st_data[0] = in_data;
  assign st_amt[0]  = in_amt;
  assign st_tag[0]  = in_tag;

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .K(k), .SHW(SHW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_ctrl  (st_ctrl[k]),
      .in_data  (st_data[k]),
      .in_amt   (st_amt[k]),
      .in_tag   (st_tag[k]),
      .out_ctrl (st_ctrl[k+1]),
      .out_data (st_data[k+1]),
      .out_amt  (st_amt[k+1]),
      .out_tag  (st_tag[k+1])
    );
  end

  logic unused_amt;
  assign unused_amt = ^st_amt[LEVELS];

  // ASR keeps the original sign in the MSB through every level, so it is the overflow fill.
  always_comb begin
    out_data = st_data[LEVELS];
    if (st_ctrl[LEVELS].ovf)
      out_data = (st_ctrl[LEVELS].mode == MODE_ASR) ? {WIDTH{st_data[LEVELS][WIDTH-1]}} : '0;
  end

  assign out_valid = st_ctrl[LEVELS].valid;
  assign out_tag   = st_tag[LEVELS];

`ifdef SHIFTER_STICKY_EN
  assign out_sticky = st_ctrl[LEVELS].sticky;
`else
  logic unused_sticky;
  assign unused_sticky = st_ctrl[LEVELS].sticky;
  assign out_sticky    = 1'b0;
`endif

endmodule
